// File: rtl/modmul_pipe_pkg.sv
// Shared constants for the modular multiplier: default modulus, mode encoding and Barrett constants.
package modmul_pipe_pkg;

  localparam int unsigned DEF_WIDTH = 12;
  localparam int unsigned DEF_Q     = 3329;
  localparam int unsigned DEF_TAGW  = 8;

  localparam logic MODE_MOD = 1'b0;
  localparam logic MODE_RAW = 1'b1;

  typedef struct packed {
    logic raw;
    logic err;
  } item_flags_t;

  function automatic int unsigned barrett_k(input int unsigned width);
    return 2 * width;
  endfunction

  function automatic longint unsigned barrett_m(input int unsigned width, input int unsigned q);
    return (64'd1 << barrett_k(width)) / 64'(q);
  endfunction

endpackage

// File: rtl/modmul_pipe_if.sv
// Operand/result handshake bundle for modmul_pipe.
interface modmul_pipe_if #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned TAGW  = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_a;
  logic [WIDTH-1:0]   in_b;
  logic               in_mode;
  logic [TAGW-1:0]    in_tag;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] out_c;
  logic [TAGW-1:0]    out_tag;
  logic               out_err;

  modport master (
    output in_valid, in_a, in_b, in_mode, in_tag, out_ready,
    input  in_ready, out_valid, out_c, out_tag, out_err
  );

  modport slave (
    input  in_valid, in_a, in_b, in_mode, in_tag, out_ready,
    output in_ready, out_valid, out_c, out_tag, out_err
  );
endinterface

// File: rtl/modmul_pipe_barrett_reduce.sv
// Stages S3-S5: Barrett quotient estimate, remainder, final conditional subtract.
module barrett_reduce
  import modmul_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned Q     = DEF_Q,
  parameter int unsigned TAGW  = DEF_TAGW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en_i,
  input  logic               valid_i,
  input  logic [2*WIDTH-1:0] p_i,
  input  item_flags_t        flags_i,
  input  logic [TAGW-1:0]    tag_i,
  output logic               valid_o,
  output logic [2*WIDTH-1:0] c_o,
  output logic [TAGW-1:0]    tag_o,
  output logic               err_o,
  output logic               busy_o
);
  localparam int unsigned PW  = 2 * WIDTH;
  localparam int unsigned K   = barrett_k(WIDTH);
  localparam int unsigned MW  = K + 1;
  localparam int unsigned PMW = PW + MW;
  localparam logic [MW-1:0]    M_C = MW'(barrett_m(WIDTH, Q));
  localparam logic [WIDTH-1:0] Q_C = WIDTH'(Q);

  logic              s3_v_q, s4_v_q, s5_v_q;
  logic [PW-1:0]     s3_p_q, s3_t_q, s4_r_q, s5_c_q;
  item_flags_t       s3_f_q, s4_f_q;
  logic              s5_err_q;
  logic [TAGW-1:0]   s3_tag_q, s4_tag_q, s5_tag_q;
  logic [PMW-1:0]    pm;
  logic [PW-1:0]     s3_t_d, tq, s4_r_d, s5_c_d;

  // Constant multiplies built from shifted adds so they map to fabric adders.
  always_comb begin
    pm = '0;
    for (int i = 0; i < int'(MW); i++) begin
      if (M_C[i]) pm = pm + (PMW'(p_i) << i);
    end
    s3_t_d = PW'(pm >> K);
  end

  // Remainder stays below 2Q, so the low PW bits of the difference are exact.
  always_comb begin
    tq = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (Q_C[i]) tq = tq + (PW'(s3_t_q) << i);
    end
    s4_r_d = s3_f_q.raw ? s3_p_q : s3_p_q - tq;
  end

  always_comb begin
    s5_c_d = s4_r_q;
    if (s4_f_q.err) begin
      s5_c_d = '0;
    end else if (!s4_f_q.raw && (s4_r_q >= PW'(Q))) begin
      s5_c_d = s4_r_q - PW'(Q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s3_v_q   <= 1'b0;
      s3_p_q   <= '0;
      s3_t_q   <= '0;
      s3_f_q   <= '0;
      s3_tag_q <= '0;
      s4_v_q   <= 1'b0;
      s4_r_q   <= '0;
      s4_f_q   <= '0;
      s4_tag_q <= '0;
      s5_v_q   <= 1'b0;
      s5_c_q   <= '0;
      s5_err_q <= 1'b0;
      s5_tag_q <= '0;
    end else if (en_i) begin
      s3_v_q   <= valid_i;
      s3_p_q   <= p_i;
      s3_t_q   <= s3_t_d;
      s3_f_q   <= flags_i;
      s3_tag_q <= tag_i;
      s4_v_q   <= s3_v_q;
      s4_r_q   <= s4_r_d;
      s4_f_q   <= s3_f_q;
      s4_tag_q <= s3_tag_q;
      s5_v_q   <= s4_v_q;
      s5_c_q   <= s5_c_d;
      s5_err_q <= s4_f_q.err;
      s5_tag_q <= s4_tag_q;
    end
  end

  assign valid_o = s5_v_q;
  assign c_o     = s5_c_q;
  assign tag_o   = s5_tag_q;
  assign err_o   = s5_err_q;
  assign busy_o  = s3_v_q | s4_v_q | s5_v_q;

endmodule

// File: rtl/modmul_pipe.sv
// Five-stage a*b mod Q (or raw a*b) pipeline with a single global stall enable.
module modmul_pipe
  import modmul_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned Q     = DEF_Q,
  parameter int unsigned TAGW  = DEF_TAGW
) (
  input  logic          clk,
  input  logic          rst,
  modmul_pipe_if.slave  bus,
  output logic          busy
);
  localparam int unsigned PW = 2 * WIDTH;

  logic             en;
  logic             out_v, tail_busy, out_err;
  logic [PW-1:0]    out_c;
  logic [TAGW-1:0]  out_tag;
  item_flags_t      s1_f_d;
  logic             s1_v_q, s2_v_q;
  logic [WIDTH-1:0] s1_a_q, s1_b_q;
  item_flags_t      s1_f_q, s2_f_q;
  logic [TAGW-1:0]  s1_tag_q, s2_tag_q;
  logic [PW-1:0]    s2_p_d, s2_p_q;

  assign en          = !out_v || bus.out_ready;
  assign bus.in_ready = en || rst;

  // Range check only matters in modular mode; raw products accept any operand.
  always_comb begin
    s1_f_d.raw = (bus.in_mode == MODE_RAW);
    s1_f_d.err = !s1_f_d.raw && ((bus.in_a >= WIDTH'(Q)) || (bus.in_b >= WIDTH'(Q)));
  end

  // Shift-and-add array multiplier.
  always_comb begin
    s2_p_d = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (s1_b_q[i]) s2_p_d = s2_p_d + (PW'(s1_a_q) << i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q   <= 1'b0;
      s1_a_q   <= '0;
      s1_b_q   <= '0;
      s1_f_q   <= '0;
      s1_tag_q <= '0;
      s2_v_q   <= 1'b0;
      s2_p_q   <= '0;
      s2_f_q   <= '0;
      s2_tag_q <= '0;
    end else if (en) begin
      s1_v_q   <= bus.in_valid;
      s1_a_q   <= bus.in_a;
      s1_b_q   <= bus.in_b;
      s1_f_q   <= s1_f_d;
      s1_tag_q <= bus.in_tag;
      s2_v_q   <= s1_v_q;
      s2_p_q   <= s2_p_d;
      s2_f_q   <= s1_f_q;
      s2_tag_q <= s1_tag_q;
    end
  end

  barrett_reduce #(.WIDTH(WIDTH), .Q(Q), .TAGW(TAGW)) u_reduce (
    .clk     (clk),
    .rst     (rst),
    .en_i    (en),
    .valid_i (s2_v_q),
    .p_i     (s2_p_q),
    .flags_i (s2_f_q),
    .tag_i   (s2_tag_q),
    .valid_o (out_v),
    .c_o     (out_c),
    .tag_o   (out_tag),
    .err_o   (out_err),
    .busy_o  (tail_busy)
  );

  assign bus.out_valid = out_v;
  assign bus.out_c     = out_c;
  assign bus.out_tag   = out_tag;
  assign bus.out_err   = out_err;
  assign busy          = s1_v_q | s2_v_q | tail_busy;

endmodule

// File: tb/tb_modmul_pipe.sv
// Directed and randomized checks of modmul_pipe against an arithmetic reference queue.
module tb_modmul_pipe;
  localparam int unsigned WIDTH = 12;
  localparam int unsigned TAGW  = 8;
  localparam int unsigned Q     = 3329;
  localparam int unsigned PW    = 2 * WIDTH;

  typedef struct {
    logic [PW-1:0]   c;
    logic [TAGW-1:0] tag;
    logic            err;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  always #5 clk = ~clk;

  modmul_pipe_if #(.WIDTH(WIDTH), .TAGW(TAGW)) bus ();
  modmul_pipe #(.WIDTH(WIDTH), .Q(Q), .TAGW(TAGW)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  exp_t            q[$];
  int              errors = 0;
  int              checks = 0;
  int              received = 0;
  bit              last_acc;
  bit              prev_stall = 1'b0;
  logic [PW-1:0]   held_c;
  logic [TAGW-1:0] held_tag;
  logic            held_err;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, expv);
    end
  endtask

  function automatic exp_t model(input int unsigned a, input int unsigned b,
                                 input bit mode, input logic [TAGW-1:0] tag);
    exp_t e;
    e.tag = tag;
    e.err = 1'b0;
    if (mode) e.c = PW'(a * b);
    else if (a >= Q || b >= Q) begin
      e.c = '0;
      e.err = 1'b1;
    end else e.c = PW'((a * b) % Q);
    return e;
  endfunction

  // Called at the negedge: handshake rules, hold stability, scoreboard.
  task automatic check_point();
    bit acc_out;
    exp_t e;
    last_acc = bus.in_valid && bus.in_ready && !rst;
    acc_out  = bus.out_valid && bus.out_ready;
    if (!rst) chk("in_ready_rule", 64'(bus.in_ready), 64'(!(bus.out_valid && !bus.out_ready)));
    if (prev_stall) begin
      chk("hold_valid", 64'(bus.out_valid), 64'd1);
      chk("hold_c", 64'(bus.out_c), 64'(held_c));
      chk("hold_tag", 64'(bus.out_tag), 64'(held_tag));
      chk("hold_err", 64'(bus.out_err), 64'(held_err));
    end
    prev_stall = bus.out_valid && !bus.out_ready && !rst;
    held_c = bus.out_c;
    held_tag = bus.out_tag;
    held_err = bus.out_err;
    if (last_acc) q.push_back(model(bus.in_a, bus.in_b, bus.in_mode, bus.in_tag));
    if (acc_out) begin
      if (q.size() == 0) chk("unexpected_out_valid", 64'(bus.out_valid), 64'd0);
      else begin
        e = q.pop_front();
        chk("out_c", 64'(bus.out_c), 64'(e.c));
        chk("out_tag", 64'(bus.out_tag), 64'(e.tag));
        chk("out_err", 64'(bus.out_err), 64'(e.err));
        received++;
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    check_point();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_item(input logic [TAGW-1:0] tag);
    bus.in_a    = WIDTH'($urandom_range(0, 3400));
    bus.in_b    = WIDTH'($urandom_range(0, 3400));
    bus.in_mode = ($urandom_range(0, 3) == 0);
    bus.in_tag  = tag;
  endtask

  // One item, then confirm it emerges exactly five edges after acceptance.
  task automatic directed(input string name, input int unsigned a, input int unsigned b,
                          input bit mode, input logic [TAGW-1:0] tag,
                          input logic [PW-1:0] exp_c, input logic exp_err);
    bus.in_valid = 1'b1;
    bus.in_a = WIDTH'(a);
    bus.in_b = WIDTH'(b);
    bus.in_mode = mode;
    bus.in_tag = tag;
    cycle();
    chk({name, "_accepted"}, 64'(last_acc), 64'd1);
    bus.in_valid = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk({name, "_early_valid"}, 64'(bus.out_valid), 64'd0);
      check_point();
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk({name, "_valid"}, 64'(bus.out_valid), 64'd1);
    chk({name, "_c"}, 64'(bus.out_c), 64'(exp_c));
    chk({name, "_tag"}, 64'(bus.out_tag), 64'(tag));
    chk({name, "_err"}, 64'(bus.out_err), 64'(exp_err));
    check_point();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired: observed no finish, required finish before 1ms");
    $fatal(1);
  end

  initial begin
    int sent;
    int k;
    int base;
    rst = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_a = 12'd7;
    bus.in_b = 12'd9;
    bus.in_mode = 1'b0;
    bus.in_tag = 8'hEE;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_out_c", 64'(bus.out_c), 64'd0);
    chk("rst_out_tag", 64'(bus.out_tag), 64'd0);
    chk("rst_out_err", 64'(bus.out_err), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.in_valid = 1'b0;

    directed("corner", 3328, 3328, 1'b0, 8'h11, 24'd1, 1'b0);
    directed("typical", 1234, 2345, 1'b0, 8'h22, 24'd829, 1'b0);
    directed("raw", 4095, 4095, 1'b1, 8'h33, 24'hFFE001, 1'b0);
    directed("range_err", 3329, 5, 1'b0, 8'h44, 24'd0, 1'b1);

    // Back-to-back burst at full throughput.
    for (int i = 0; i < 8; i++) begin
      bus.in_valid = 1'b1;
      rand_item(TAGW'(8'h50 + i));
      cycle();
      chk("burst_accepted", 64'(last_acc), 64'd1);
    end
    bus.in_valid = 1'b0;
    repeat (6) cycle();
    chk("burst_drained", 64'(q.size()), 64'd0);

    // Backpressure: out_ready low 3 cycles of every 7.
    sent = 0;
    k = 0;
    base = received;
    rand_item(TAGW'(0));
    while ((received - base) < 20 && k < 400) begin
      bus.out_ready = ((k % 7) >= 3);
      bus.in_valid = (sent < 20);
      cycle();
      if (last_acc) begin
        sent++;
        rand_item(TAGW'(sent));
      end
      k++;
    end
    chk("bp_received", 64'(received - base), 64'd20);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) cycle();

    // Reset with four items in flight; none may ever appear.
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_a = WIDTH'($urandom_range(0, Q - 1));
      bus.in_b = WIDTH'($urandom_range(0, Q - 1));
      bus.in_mode = 1'b0;
      bus.in_tag = TAGW'(8'hA0 + i);
      cycle();
    end
    bus.in_tag = 8'hEE;
    rst = 1'b1;
    @(negedge clk);
    chk("busy_before_rst", 64'(busy), 64'd1);
    chk("rst_mid_in_ready", 64'(bus.in_ready), 64'd1);
    check_point();
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    q.delete();
    prev_stall = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", 64'(busy), 64'd0);
    chk("post_rst_out_valid", 64'(bus.out_valid), 64'd0);
    check_point();
    @(posedge clk);
    #1;
    repeat (10) cycle();
    chk("post_rst_idle_busy", 64'(busy), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
